alu_ex_stage: RTL

Execute stage of the integer pipeline: takes the two selected ALU operands (rs1/pc/zero and rs2/shamt/immediate, already chosen upstream) plus an operation code and destination register, and computes the result into a registered output slot. It has a valid/ready handshake on both sides. Single-cycle operations complete in one cycle; MUL runs on an iterative 32-step shift-add engine. The output feeds the writeback/forwarding stage.

---
 rtl/alu_ex_if.sv | 27 ++
 rtl/alu_ex_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_ex_if.sv
// Handshake and data bundle between issue, the ALU execute stage and writeback.
interface alu_ex_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] aluin1;
  logic [XLEN-1:0] aluin2;
  logic [3:0]      alu_op;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            busy;

  modport master (
    output flush, in_valid, aluin1, aluin2, alu_op, rd_in, out_ready,
    input  in_ready, out_valid, result, rd_out, busy
  );

  modport slave (
    input  flush, in_valid, aluin1, aluin2, alu_op, rd_in, out_ready,
    output in_ready, out_valid, result, rd_out, busy
  );
endinterface

// File: rtl/alu_ex_stage.sv
// Integer execute stage: single-cycle ALU ops plus an iterative shift-add MUL,
// with a one-entry registered output slot and valid/ready on both sides.
module alu_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_ex_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_PASS2 = 4'd10,
    OP_MUL   = 4'd11
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [4:0]      rd_hold;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            in_ready;
  logic            accept;
  logic            is_mul;
  logic            last_step;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;

  assign in_ready  = (state == IDLE) && (!out_valid || bus.out_ready) && !bus.flush;
  assign accept    = bus.in_valid && in_ready;
  assign is_mul    = (bus.alu_op == OP_MUL);
  assign last_step = (count == CW'(XLEN - 1));
  assign shamt     = bus.aluin2[4:0];
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.rd_out    = rd_out;
  assign bus.busy      = (state == MUL);

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OP_ADD:   alu_res = bus.aluin1 + bus.aluin2;
      OP_SUB:   alu_res = bus.aluin1 - bus.aluin2;
      OP_SLL:   alu_res = bus.aluin1 << shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(bus.aluin1) < $signed(bus.aluin2)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, bus.aluin1 < bus.aluin2};
      OP_XOR:   alu_res = bus.aluin1 ^ bus.aluin2;
      OP_SRL:   alu_res = bus.aluin1 >> shamt;
      OP_SRA:   alu_res = $signed(bus.aluin1) >>> shamt;
      OP_OR:    alu_res = bus.aluin1 | bus.aluin2;
      OP_AND:   alu_res = bus.aluin1 & bus.aluin2;
      OP_PASS2: alu_res = bus.aluin2;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_mul) state_d = MUL;
        MUL:     if (last_step) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      rd_hold   <= '0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      // Loads below override the drain so a same-edge refill keeps out_valid high.
      if (accept) begin
        if (is_mul) begin
          mcand   <= bus.aluin1;
          mplier  <= bus.aluin2;
          acc     <= '0;
          count   <= '0;
          rd_hold <= bus.rd_in;
        end else begin
          result    <= alu_res;
          rd_out    <= bus.rd_in;
          out_valid <= 1'b1;
        end
      end
      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (last_step) begin
          result    <= acc_next;
          rd_out    <= rd_hold;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
